// File: rtl/dpd_coeff_loader_pkg.sv
// Shared types and sizing for the DPD coefficient loader and its banks.
package dpd_pkg;

    localparam int unsigned COEFF_WIDTH = 16;
    localparam int unsigned FRAC_SZ     = 12;
    localparam int unsigned M           = 2;
    localparam int unsigned K           = 3;
    localparam int unsigned TOTAL_TERMS = (M + 1) * K;
    localparam int unsigned AW          = $clog2(TOTAL_TERMS);

    typedef struct packed {
        logic signed [COEFF_WIDTH-1:0] re;
        logic signed [COEFF_WIDTH-1:0] im;
    } coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PENDING
    } ld_state_e;

    // Pass-through DPD: unity gain on term 0, every other term zero.
    function automatic coeff_t identity_coeff(input int unsigned idx);
        coeff_t c;
        c = '0;
        if (idx == 0) begin
            c.re = COEFF_WIDTH'(1 << FRAC_SZ);
        end
        return c;
    endfunction

endpackage

// File: rtl/dpd_coeff_loader_if.sv
// Coefficient stream (host/adaptation side) and coefficient read port (MAC side).
interface dpd_coeff_loader_if;
    import dpd_pkg::*;

    logic                          load_start;
    logic                          load_valid;
    logic                          load_ready;
    logic signed [COEFF_WIDTH-1:0] load_re;
    logic signed [COEFF_WIDTH-1:0] load_im;
    logic                          load_last;

    logic                          enable;
    logic [AW-1:0]                 addr;
    logic signed [COEFF_WIDTH-1:0] data_re;
    logic signed [COEFF_WIDTH-1:0] data_im;

    modport master (
        output load_start, load_valid, load_re, load_im, load_last,
        output enable, addr,
        input  load_ready, data_re, data_im
    );

    modport slave (
        input  load_start, load_valid, load_re, load_im, load_last,
        input  enable, addr,
        output load_ready, data_re, data_im
    );

endinterface

// File: rtl/dpd_coeff_loader_bank.sv
// One coefficient bank: synchronous write, registered read, reset to identity.
module dpd_coeff_bank
    import dpd_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  coeff_t        wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    output coeff_t        rdata
);

    coeff_t mem_q [TOTAL_TERMS];
    coeff_t mem_d [TOTAL_TERMS];
    coeff_t rdata_q;
    coeff_t rdata_d;

    // Next-state of storage and read register; out-of-range reads return zero.
    always_comb begin
        for (int unsigned i = 0; i < TOTAL_TERMS; i++) begin
            mem_d[i] = mem_q[i];
            if (we && (waddr == AW'(i))) begin
                mem_d[i] = wdata;
            end
        end
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            for (int unsigned i = 0; i < TOTAL_TERMS; i++) begin
                if (raddr == AW'(i)) begin
                    rdata_d = mem_q[i];
                end
            end
        end
    end

    // Storage and read register, restored to the identity set on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TOTAL_TERMS; i++) begin
                mem_q[i] <= identity_coeff(i);
            end
            rdata_q <= '0;
        end else begin
            for (int unsigned i = 0; i < TOTAL_TERMS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dpd_coeff_loader.sv
// Double-buffered DPD coefficient store: loads a set into the shadow bank and
// swaps it in atomically while the MAC is idle.
module dpd_coeff_loader
    import dpd_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    dpd_coeff_loader_if.slave   lif,
    input  logic                mac_busy,
    output logic                active_bank,
    output logic                swap_pulse,
    output logic                load_err
);

    localparam logic [AW-1:0] LAST_IDX = AW'(TOTAL_TERMS - 1);

    ld_state_e     state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic          active_bank_q, active_bank_d;
    logic          load_ready_q, load_ready_d;
    logic          swap_pulse_q, swap_pulse_d;
    logic          load_err_q, load_err_d;
    logic          rd_sel_q, rd_sel_d;

    logic          accept;
    coeff_t        wdata;
    coeff_t        rdata0;
    coeff_t        rdata1;
    coeff_t        rd_word;

    assign accept = (state_q == LOAD) && lif.load_valid && load_ready_q;
    assign wdata  = '{re: lif.load_re, im: lif.load_im};

    // Loader FSM next-state; outputs are computed here and registered below.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        active_bank_d = active_bank_q;
        load_ready_d  = load_ready_q;
        swap_pulse_d  = 1'b0;
        load_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready_d = 1'b0;
                if (lif.load_start) begin
                    state_d      = LOAD;
                    count_d      = '0;
                    load_ready_d = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (count_q == LAST_IDX) begin
                        load_ready_d = 1'b0;
                        if (lif.load_last) begin
                            state_d = PENDING;
                        end else begin
                            state_d    = IDLE;
                            load_err_d = 1'b1;
                        end
                    end else if (lif.load_last) begin
                        state_d      = IDLE;
                        load_ready_d = 1'b0;
                        load_err_d   = 1'b1;
                    end else begin
                        count_d = count_q + AW'(1);
                    end
                end
            end
            PENDING: begin
                load_ready_d = 1'b0;
                if (!mac_busy) begin
                    active_bank_d = ~active_bank_q;
                    swap_pulse_d  = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                load_ready_d = 1'b0;
            end
        endcase
    end

    // Bank that was active when a read was issued selects the returned word,
    // so a read on the swap edge still sees the old set.
    always_comb begin
        rd_sel_d = lif.enable ? active_bank_q : rd_sel_q;
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            active_bank_q <= 1'b0;
            load_ready_q  <= 1'b0;
            swap_pulse_q  <= 1'b0;
            load_err_q    <= 1'b0;
            rd_sel_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            active_bank_q <= active_bank_d;
            load_ready_q  <= load_ready_d;
            swap_pulse_q  <= swap_pulse_d;
            load_err_q    <= load_err_d;
            rd_sel_q      <= rd_sel_d;
        end
    end

    dpd_coeff_bank u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && active_bank_q),
        .waddr (count_q),
        .wdata (wdata),
        .rd_en (lif.enable),
        .raddr (lif.addr),
        .rdata (rdata0)
    );

    dpd_coeff_bank u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && !active_bank_q),
        .waddr (count_q),
        .wdata (wdata),
        .rd_en (lif.enable),
        .raddr (lif.addr),
        .rdata (rdata1)
    );

    assign rd_word        = rd_sel_q ? rdata1 : rdata0;
    assign lif.data_re    = rd_word.re;
    assign lif.data_im    = rd_word.im;
    assign lif.load_ready = load_ready_q;
    assign active_bank    = active_bank_q;
    assign swap_pulse     = swap_pulse_q;
    assign load_err       = load_err_q;

endmodule

// File: tb/tb_dpd_coeff_loader.sv
// Directed + randomized bench for dpd_coeff_loader against a set-level bank model.
module tb_dpd_coeff_loader;
    import dpd_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mac_busy = 1'b0;
    logic active_bank;
    logic swap_pulse;
    logic load_err;

    int errors = 0;
    int checks = 0;

    // Model: contents of both banks and which one is active.
    int mre [2][TOTAL_TERMS];
    int mim [2][TOTAL_TERMS];
    int mact;

    dpd_coeff_loader_if lif();

    dpd_coeff_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lif         (lif),
        .mac_busy    (mac_busy),
        .active_bank (active_bank),
        .swap_pulse  (swap_pulse),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < TOTAL_TERMS; i++) begin
                mre[b][i] = (i == 0) ? (1 << FRAC_SZ) : 0;
                mim[b][i] = 0;
            end
        end
        mact = 0;
    endtask

    function automatic int exp_re(input int bank, input int a);
        return (a < TOTAL_TERMS) ? mre[bank][a] : 0;
    endfunction

    function automatic int exp_im(input int bank, input int a);
        return (a < TOTAL_TERMS) ? mim[bank][a] : 0;
    endfunction

    task automatic read_chk(input int a);
        logic [AW-1:0] av;
        av = AW'(a);
        lif.enable = 1'b1;
        lif.addr   = av;
        tick();
        lif.enable = 1'b0;
        chk($sformatf("rd_re[%0d]", a), lif.data_re, exp_re(mact, a));
        chk($sformatf("rd_im[%0d]", a), lif.data_im, exp_im(mact, a));
    endtask

    task automatic read_all();
        for (int a = 0; a < TOTAL_TERMS; a++) begin
            read_chk(a);
        end
    endtask

    // last_idx < 0: no load_last at all; rst_at >= 0: reset before that beat.
    task automatic do_load(input int last_idx, input int busy_cycles, input int rst_at, input bit seq_vals);
        int nb;
        int shadow;
        int oldact;
        int v_re;
        int v_im;
        int gap;
        int a;
        nb     = (last_idx >= 0) ? last_idx + 1 : TOTAL_TERMS;
        shadow = 1 - mact;
        oldact = mact;
        mac_busy = (busy_cycles > 0);
        lif.load_start = 1'b1;
        tick();
        lif.load_start = 1'b0;
        chk("ready_after_start", lif.load_ready, 1);
        for (int i = 0; i < nb; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                lif.load_start = $urandom_range(0, 1) != 0;
                tick();
                lif.load_start = 1'b0;
                chk("ready_in_gap", lif.load_ready, 1);
            end
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_ready", lif.load_ready, 0);
                chk("rst_active", active_bank, 0);
                chk("rst_swap", swap_pulse, 0);
                chk("rst_err", load_err, 0);
                chk("rst_data_re", lif.data_re, 0);
                chk("rst_data_im", lif.data_im, 0);
                reset_model();
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            if (seq_vals) begin
                v_re = i + 1;
                v_im = -(i + 1);
            end else begin
                v_re = int'($urandom_range(0, 65535)) - 32768;
                v_im = int'($urandom_range(0, 65535)) - 32768;
            end
            lif.load_re    = v_re[COEFF_WIDTH-1:0];
            lif.load_im    = v_im[COEFF_WIDTH-1:0];
            lif.load_valid = 1'b1;
            lif.load_last  = (i == last_idx);
            lif.load_start = $urandom_range(0, 1) != 0;
            mre[shadow][i] = v_re;
            mim[shadow][i] = v_im;
            tick();
            lif.load_valid = 1'b0;
            lif.load_last  = 1'b0;
            lif.load_start = 1'b0;
        end
        if (last_idx == TOTAL_TERMS - 1) begin
            chk("pend_ready", lif.load_ready, 0);
            chk("pend_err", load_err, 0);
            chk("pend_swap", swap_pulse, 0);
            chk("pend_active", active_bank, oldact);
            for (int c = 0; c < busy_cycles; c++) begin
                lif.load_start = (c == 5);
                read_chk(int'($urandom_range(0, TOTAL_TERMS - 1)));
                lif.load_start = 1'b0;
                chk("busy_no_swap", swap_pulse, 0);
                chk("busy_active", active_bank, oldact);
                chk("busy_ready", lif.load_ready, 0);
            end
            mac_busy = 1'b0;
            a = int'($urandom_range(0, TOTAL_TERMS - 1));
            lif.enable = 1'b1;
            lif.addr   = AW'(a);
            tick();
            lif.enable = 1'b0;
            chk("swap_pulse", swap_pulse, 1);
            chk("swap_active", active_bank, shadow);
            chk("swap_edge_rd_re", lif.data_re, exp_re(oldact, a));
            chk("swap_edge_rd_im", lif.data_im, exp_im(oldact, a));
            mact = shadow;
            tick();
            chk("swap_pulse_end", swap_pulse, 0);
            chk("idle_ready", lif.load_ready, 0);
        end else begin
            chk("err_pulse", load_err, 1);
            chk("err_ready", lif.load_ready, 0);
            chk("err_no_swap", swap_pulse, 0);
            chk("err_active", active_bank, oldact);
            lif.load_valid = 1'b1;
            tick();
            chk("err_pulse_end", load_err, 0);
            tick();
            lif.load_valid = 1'b0;
            chk("err_idle_ready", lif.load_ready, 0);
        end
    endtask

    initial begin
        lif.load_start = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_re    = '0;
        lif.load_im    = '0;
        lif.load_last  = 1'b0;
        lif.enable     = 1'b0;
        lif.addr       = '0;
        reset_model();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("reset_ready", lif.load_ready, 0);
        chk("reset_swap", swap_pulse, 0);
        chk("reset_err", load_err, 0);
        chk("reset_active", active_bank, 0);
        chk("reset_data_re", lif.data_re, 0);
        chk("reset_data_im", lif.data_im, 0);

        read_all();
        for (int a = TOTAL_TERMS; a < (1 << AW); a++) begin
            read_chk(a);
        end

        // Data holds while enable is low.
        read_chk(0);
        lif.addr = AW'(3);
        tick();
        chk("hold_re", lif.data_re, exp_re(mact, 0));

        // Beats offered outside LOAD are not consumed.
        lif.load_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_valid_ready", lif.load_ready, 0);
        end
        lif.load_valid = 1'b0;

        do_load(TOTAL_TERMS - 1, 0, -1, 1'b1);
        chk("load1_active", active_bank, 1);
        read_all();

        do_load(TOTAL_TERMS - 1, 20, -1, 1'b0);
        read_all();

        do_load(4, 0, -1, 1'b0);
        read_all();

        do_load(-1, 0, -1, 1'b0);
        read_all();
        do_load(TOTAL_TERMS - 1, 0, -1, 1'b0);
        read_all();

        do_load(TOTAL_TERMS - 1, 0, 4, 1'b0);
        read_chk(0);
        chk("post_rst_active", active_bank, 0);
        do_load(TOTAL_TERMS - 1, 0, -1, 1'b0);
        chk("post_rst_load_active", active_bank, 1);
        read_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dpd_coeff_loader.md
Name: dpd_coeff_loader

Overview:
- Writer side of the DPD coefficient read interface: accepts a streamed coefficient set, stores it in a shadow bank, and atomically swaps it into the active bank.
- The MAC array reads the active bank through the same addr/enable/data port the coefficient ROM provides today. This makes the ROM replaceable by a run-time-updatable store fed by the adaptation/host path.
- Bank swap happens only while the MAC is idle, so no output sample ever mixes coefficients from two sets.

Parameters:
- COEFF_WIDTH, 16, signed coefficient width (re and im).
- FRAC_SZ, 12, fractional bits; reset value of term 0 real = 1<<FRAC_SZ.
- M, 2, memory depth (taps 0..M).
- K, 3, polynomial order.
- TOTAL_TERMS, (M+1)*K, derived localparam; number of coefficients per set.
- AW, $clog2(TOTAL_TERMS), address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  pulse: begin a new set (accepted only in IDLE).
- load_valid  in  1  beat valid.
- load_ready  out  1  beat accepted when load_valid && load_ready.
- load_re  in  COEFF_WIDTH  coefficient real part.
- load_im  in  COEFF_WIDTH  coefficient imaginary part.
- load_last  in  1  marks final beat of the set.
- mac_busy  in  1  MAC array is mid-sample; swap is forbidden.
- enable  in  1  read request (the MAC's coeff_req).
- addr  in  AW  read address (term_idx).
- data_re  out  COEFF_WIDTH  active-bank coefficient real part.
- data_im  out  COEFF_WIDTH  active-bank coefficient imaginary part.
- active_bank  out  1  index of the bank currently being read.
- swap_pulse  out  1  one-cycle pulse on the cycle the new bank becomes active.
- load_err  out  1  one-cycle pulse when a malformed set is discarded.

Behaviour:
- Storage: two banks of TOTAL_TERMS x {re, im}.
- Reset (async, rst_n=0):
  - Both banks cleared; term 0 re = 1<<FRAC_SZ in both banks (pass-through DPD).
  - active_bank=0; state=IDLE; count=0.
  - load_ready=0; data_re/im=0; swap_pulse=0; load_err=0.
- Read port:
  - 1-cycle latency: if enable, data <= active[addr] at the next clk edge. If !enable, data holds its value.
  - addr >= TOTAL_TERMS returns 0.
  - A read in the same cycle as the swap edge returns the OLD bank; the first read after swap_pulse returns the new bank.
- FSM states: IDLE, LOAD, PENDING.
- IDLE:
  - load_ready=0.
  - load_start -> LOAD, count=0.
- LOAD:
  - load_ready=1.
  - Each accepted beat writes shadow[count] (shadow = !active_bank), then count++.
  - Accepted beat with load_last and count==TOTAL_TERMS-1 -> PENDING.
  - Accepted beat with load_last and count<TOTAL_TERMS-1 -> load_err pulse, IDLE; active bank untouched.
  - Accepted beat at count==TOTAL_TERMS-1 without load_last -> load_err pulse, IDLE.
  - load_start while in LOAD is ignored.
- PENDING:
  - load_ready=0; load_start ignored.
  - First cycle with mac_busy==0 -> active_bank toggles at that edge, swap_pulse=1 for one cycle, state -> IDLE.
  - While mac_busy==1, remain in PENDING indefinitely.
- No write ever targets the active bank. The shadow bank keeps its stale contents until overwritten.
- rst_n asserted mid-LOAD or mid-PENDING: the partial set is discarded and the reset values are restored.
- load_valid when load_ready=0: beat is not consumed; no state change.

Decomposition:
- Package dpd_pkg holds:
  - Localparams for TOTAL_TERMS and AW.
  - Typedef coeff_t (struct of signed re/im, COEFF_WIDTH).
  - FSM enum ld_state_e {IDLE, LOAD, PENDING}.
- One sub-module, dpd_coeff_bank: single bank with a synchronous write port, a registered read port, and reset-to-identity. It is instantiated twice. The loader holds the FSM, count, and bank-select/mux logic.

Test Plan:
- Reset then read addr 0..8 with enable -> data_re = 4096, 0 x8; data_im all 0; active_bank=0.
- load_start; 9 beats re=i+1, im=-(i+1), last on beat 9; mac_busy=0 -> swap_pulse one cycle after PENDING entry; active_bank=1; reads return re=1..9, im=-1..-9.
- Same load with mac_busy=1 held 20 cycles -> no swap and reads still return the old set. mac_busy drops -> swap_pulse on the next edge.
- load_last on beat 5 -> load_err pulse; state IDLE; reads unchanged; load_ready=0.
- 9 beats without load_last -> load_err on beat 9. Then a valid reload of 9 beats -> swap succeeds.
- Reset asserted at beat 4 of a load -> all outputs return to reset values immediately; term 0 reads 4096; the next full load swaps to bank 1.
